// File: rtl/cmip_pkt_chk.sv
// cmip_pkt_chk -- receive-side checker for cmip/aurora test-pattern AXI-Stream.
// Every accepted beat is checked against the expected pattern, either the
// per-packet beat index or a running 32-bit counter. The block also checks
// packet length, the SOP marker (tuser) and tkeep. Results go into saturating
// counters, sticky error flags and a first-data-error capture for readback.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   cfg_rst          sync soft clear of counters/flags/captures/lock
//   cfg_en           checker enable (0 -> IDLE, tready low)
//   cfg_len          expected beats per packet (0 means 8)
//   cfg_mode         [1] 0=beat index / 1=running counter, [4] random backpressure
//   sts_*            registered status (packet/error counts, sticky flags, capture, busy)
//   s_axis_*         AXI-Stream slave; tuser marks SOP on the first beat
module cmip_pkt_chk #(
  parameter int DATA_WD = 32,
  parameter int CFG_WD  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_rst,
  input  logic                 cfg_en,
  input  logic [CFG_WD-1:0]    cfg_len,
  input  logic [CFG_WD-1:0]    cfg_mode,
  output logic [CFG_WD-1:0]    sts_pkt_cnt,
  output logic [CFG_WD-1:0]    sts_err_cnt,
  output logic [3:0]           sts_err_flags,
  output logic [DATA_WD-1:0]   sts_err_exp,
  output logic [DATA_WD-1:0]   sts_err_got,
  output logic                 sts_busy,
  input  logic [DATA_WD-1:0]   s_axis_tdata,
  input  logic [DATA_WD/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CFG_WD-1:0]   idx_q, idx_d;
  logic [CFG_WD-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CFG_WD-1:0]   err_cnt_q, err_cnt_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_WD-1:0]  err_exp_q, err_exp_d;
  logic [DATA_WD-1:0]  err_got_q, err_got_d;
  logic [31:0]         exp_q, exp_d;
  logic                lock_q, lock_d;
  logic                mode1_q, mode1_d;
  logic                cap_q, cap_d;
  logic                ovr_q, ovr_d;
  logic                tready_q, tready_d;

  logic                acc, lock_eff;
  logic [CFG_WD-1:0]   last_idx;
  logic                keep_err, sop_err, len_err, data_err;

  // Bits of cfg_mode that have no function here.
  logic unused_mode;
  assign unused_mode = ^{cfg_mode[CFG_WD-1:5], cfg_mode[3:2], cfg_mode[0]};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    flags_d   = flags_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
    exp_d     = exp_q;
    lock_d    = lock_q;
    cap_d     = cap_q;
    ovr_d     = ovr_q;
    mode1_d   = cfg_mode[1];

    acc      = s_axis_tvalid && tready_q;
    last_idx = ((cfg_len == '0) ? CFG_WD'(8) : cfg_len) - CFG_WD'(1);
    // A mode[1] change drops the counter lock in the same cycle.
    lock_eff = lock_q && (cfg_mode[1] == mode1_q);
    if (!lock_eff) lock_d = 1'b0;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
    if (cfg_mode[4]) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    keep_err = (s_axis_tkeep != '1);
    sop_err  = (s_axis_tuser != (state_q == HEAD));
    // Once an overrun has been reported, the closing tlast only resyncs.
    len_err  = s_axis_tlast ? ((idx_q != last_idx) && !ovr_q) : (idx_q == last_idx);
    data_err = cfg_mode[1] ? (lock_eff && (s_axis_tdata != exp_q[DATA_WD-1:0]))
                           : (s_axis_tdata != idx_q[DATA_WD-1:0]);

    if (acc) begin
      flags_d = flags_q | {keep_err, sop_err, len_err, data_err};
      if ((keep_err || sop_err || len_err || data_err) && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + CFG_WD'(1);
      if (s_axis_tlast && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + CFG_WD'(1);
      if (data_err && !cap_q) begin
        cap_d     = 1'b1;
        err_exp_d = exp_q[DATA_WD-1:0];
        err_got_d = s_axis_tdata;
        if (!cfg_mode[1]) err_exp_d = idx_q[DATA_WD-1:0];
      end
      if (cfg_mode[1]) begin
        // After lock the expected value free-runs, so one corrupted beat
        // costs exactly one error and does not shift the sequence.
        exp_d  = lock_eff ? exp_q + 32'd1 : 32'(s_axis_tdata) + 32'd1;
        lock_d = 1'b1;
      end
      if (s_axis_tlast) begin
        idx_d   = '0;
        ovr_d   = 1'b0;
        state_d = HEAD;
      end else begin
        idx_d   = idx_q + CFG_WD'(1);
        ovr_d   = ovr_q || (idx_q == last_idx);
        state_d = BODY;
      end
    end

    if (!cfg_en) begin
      state_d = IDLE;
      idx_d   = '0;
      ovr_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = HEAD;
    end

    if (cfg_rst) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
      flags_d   = '0;
      err_exp_d = '0;
      err_got_d = '0;
      exp_d     = exp_q;
      cap_d     = 1'b0;
      lock_d    = 1'b0;
      ovr_d     = 1'b0;
      idx_d     = '0;
      state_d   = cfg_en ? HEAD : IDLE;
    end

    // Registered so tready never has a path from tvalid.
    tready_d = (state_d != IDLE) && (lfsr_d[0] || !cfg_mode[4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= 16'hACE1;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      flags_q   <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
      exp_q     <= '0;
      lock_q    <= 1'b0;
      mode1_q   <= 1'b0;
      cap_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      flags_q   <= flags_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
      exp_q     <= exp_d;
      lock_q    <= lock_d;
      mode1_q   <= mode1_d;
      cap_q     <= cap_d;
      ovr_q     <= ovr_d;
      tready_q  <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign sts_pkt_cnt   = pkt_cnt_q;
  assign sts_err_cnt   = err_cnt_q;
  assign sts_err_flags = flags_q;
  assign sts_err_exp   = err_exp_q;
  assign sts_err_got   = err_got_q;
  assign sts_busy      = (state_q == BODY);

endmodule

// File: tb/tb_cmip_pkt_chk.sv
// Directed bench for cmip_pkt_chk: hand-computed expectations per scenario.
module tb_cmip_pkt_chk;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_rst = 1'b0, cfg_en = 1'b0;
  logic [31:0] cfg_len = '0, cfg_mode = '0;
  logic [31:0] sts_pkt_cnt, sts_err_cnt, sts_err_exp, sts_err_got;
  logic [3:0]  sts_err_flags;
  logic        sts_busy;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '1;
  logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;

  int n_chk = 0, n_pass = 0, n_stall = 0;

  always #5 clk = ~clk;

  cmip_pkt_chk #(.DATA_WD(32), .CFG_WD(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
    .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .sts_pkt_cnt(sts_pkt_cnt), .sts_err_cnt(sts_err_cnt), .sts_err_flags(sts_err_flags),
    .sts_err_exp(sts_err_exp), .sts_err_got(sts_err_got), .sts_busy(sts_busy),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One beat; waits (bounded) for tready, then lets the posedge accept it.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic u, input logic l);
    int w = 0;
    @(negedge clk);
    tdata = d; tkeep = k; tuser = u; tlast = l; tvalid = 1'b1;
    while (!tready && w < 200) begin
      n_stall++;
      @(negedge clk);
      w++;
    end
    if (!tready) begin
      chk("tready_timeout", {31'd0, tready}, 32'd1);
      tvalid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // n beats with data d0+i; optional corrupt beat, missing SOP, bad keep beat.
  task automatic send_pkt(input int n, input logic [31:0] d0, input int bad_i,
                          input logic [31:0] bad_d, input logic sop, input int keep_i);
    for (int i = 0; i < n; i++)
      send((i == bad_i) ? bad_d : d0 + 32'(i), (i == keep_i) ? 4'b0111 : 4'b1111,
           (i == 0) ? sop : 1'b0, i == n - 1);
  endtask

  task automatic idle;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    tvalid = 1'b0;
    cfg_rst = 1'b1;
    @(negedge clk);
    cfg_rst = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] pkt, input logic [31:0] err,
                            input logic [3:0] fl);
    chk({tag, "_pkt"}, sts_pkt_cnt, pkt);
    chk({tag, "_err"}, sts_err_cnt, err);
    chk({tag, "_flags"}, {28'd0, sts_err_flags}, {28'd0, fl});
  endtask

  logic tr_before;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_status("reset", 0, 0, 4'b0000);
    chk("reset_exp", sts_err_exp, 0);
    chk("reset_got", sts_err_got, 0);
    chk("reset_tready", {31'd0, tready}, 0);
    chk("reset_busy", {31'd0, sts_busy}, 0);

    // Index mode, default length 8.
    cfg_en = 1'b1; cfg_len = 0; cfg_mode = 0;
    @(negedge clk);
    chk("en_tready", {31'd0, tready}, 1);
    send(0, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    chk("busy_body", {31'd0, sts_busy}, 1);
    for (int i = 1; i < 8; i++) send(i, 4'hF, 1'b0, i == 7);
    for (int p = 0; p < 2; p++) send_pkt(8, 0, -1, 0, 1'b1, -1);
    idle;
    chk_status("idx8", 3, 0, 4'b0000);
    chk("idx8_busy", {31'd0, sts_busy}, 0);

    // Counter mode with one corrupted beat.
    pulse_rst;
    cfg_mode = 32'h2; cfg_len = 5;
    for (int p = 0; p < 4; p++) send_pkt(5, 32'h10 + 32'(5 * p), (p == 1) ? 3 : -1, 32'hAA, 1'b1, -1);
    idle;
    chk_status("cnt", 4, 1, 4'b0001);
    chk("cnt_exp", sts_err_exp, 32'h18);
    chk("cnt_got", sts_err_got, 32'hAA);

    // Length errors: early tlast, then overrun.
    pulse_rst;
    cfg_mode = 0; cfg_len = 4;
    send_pkt(3, 0, -1, 0, 1'b1, -1);
    send_pkt(6, 0, -1, 0, 1'b1, -1);
    idle;
    chk_status("len", 2, 2, 4'b0010);

    // Random backpressure.
    pulse_rst;
    cfg_mode = 32'h10; cfg_len = 16; n_stall = 0;
    @(negedge clk);
    tr_before = tready;
    tvalid = ~tvalid;
    #1 chk("tready_vs_tvalid", {31'd0, tready}, {31'd0, tr_before});
    tvalid = 1'b0;
    for (int p = 0; p < 100; p++) send_pkt(16, 0, -1, 0, 1'b1, -1);
    idle;
    chk_status("bp", 100, 0, 4'b0000);
    chk("bp_stalled", {31'd0, n_stall > 0}, 1);

    // SOP and keep errors.
    pulse_rst;
    cfg_mode = 0; cfg_len = 0;
    send_pkt(8, 0, -1, 0, 1'b0, -1);
    send_pkt(8, 0, -1, 0, 1'b1, 3);
    idle;
    chk_status("sopkeep", 2, 2, 4'b1100);

    // Disable mid-packet, re-enable, clean packet, then soft clear.
    pulse_rst;
    for (int i = 0; i < 4; i++) send(i, 4'hF, i == 0, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    cfg_en = 1'b0;
    @(negedge clk);
    chk("dis_tready", {31'd0, tready}, 0);
    chk("dis_busy", {31'd0, sts_busy}, 0);
    cfg_en = 1'b1;
    send_pkt(8, 0, -1, 0, 1'b1, -1);
    idle;
    chk_status("reen", 1, 0, 4'b0000);
    pulse_rst;
    chk_status("clr", 0, 0, 4'b0000);
    chk("clr_exp", sts_err_exp, 0);
    chk("clr_got", sts_err_got, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
